xif_copro_result_stage: RTL and testbench

Writeback and result stage of the XIF coprocessor, directly downstream of the coprocessor execution unit and the memory-instruction path.
- Accepts completed operations from two sources:
  - the execution unit (data plus copro tag: id, addr, rd_is_copro);
  - the memory path (load data plus mem metadata).
- Writes coprocessor-register results into the coprocessor register file.
- Queues one x_result_t per instruction in a small FIFO and drives the XIF result valid/ready handshake towards the core.

---
 rtl/xif_copro_result_stage_if.sv | 82 ++++++++
 rtl/xif_copro_result_stage.sv | 188 ++++++++++++++++++
 tb/tb_xif_copro_result_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_copro_result_stage_if.sv
// rtl/xif_copro_result_stage_if.sv - shared XIF coprocessor types and result stage bus interface
// xif_copro_pkg    : X_ID_WIDTH, X_RFW_WIDTH, mem_metadata_t, x_result_t
// xif_copro_result_stage_if
//   ex_*     : execution unit result handshake (valid/ready, id, rd, rd_is_copro, data)
//   mem_*    : memory path result handshake (valid/ready, meta, rd_is_copro, data)
//   crf_*    : coprocessor register file write port
//   x_result : XIF result handshake towards the core
//   modports : slave (result stage side), master (upstream/core side)

package xif_copro_pkg;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFW_WIDTH = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
        logic                  dbg;
    } mem_metadata_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic [5:0]             ecsdata;
        logic [2:0]             ecswe;
        logic                   exc;
        logic [5:0]             exccode;
        logic                   err;
        logic                   dbg;
    } x_result_t;

endpackage

interface xif_copro_result_stage_if;

    import xif_copro_pkg::*;

    logic                   ex_valid_i;
    logic                   ex_ready_o;
    logic [X_ID_WIDTH-1:0]  ex_id_i;
    logic [4:0]             ex_rd_i;
    logic                   ex_rd_is_copro_i;
    logic [X_RFW_WIDTH-1:0] ex_data_i;

    logic                   mem_valid_i;
    logic                   mem_ready_o;
    mem_metadata_t          mem_meta_i;
    logic                   mem_rd_is_copro_i;
    logic [X_RFW_WIDTH-1:0] mem_data_i;

    logic                   crf_we_o;
    logic [4:0]             crf_waddr_o;
    logic [X_RFW_WIDTH-1:0] crf_wdata_o;

    logic                   x_result_valid_o;
    logic                   x_result_ready_i;
    x_result_t              x_result_o;

    modport slave (
        input  ex_valid_i, ex_id_i, ex_rd_i, ex_rd_is_copro_i, ex_data_i,
        input  mem_valid_i, mem_meta_i, mem_rd_is_copro_i, mem_data_i,
        input  x_result_ready_i,
        output ex_ready_o, mem_ready_o,
        output crf_we_o, crf_waddr_o, crf_wdata_o,
        output x_result_valid_o, x_result_o
    );

    modport master (
        output ex_valid_i, ex_id_i, ex_rd_i, ex_rd_is_copro_i, ex_data_i,
        output mem_valid_i, mem_meta_i, mem_rd_is_copro_i, mem_data_i,
        output x_result_ready_i,
        input  ex_ready_o, mem_ready_o,
        input  crf_we_o, crf_waddr_o, crf_wdata_o,
        input  x_result_valid_o, x_result_o
    );

endinterface

// File: rtl/xif_copro_result_stage.sv
// rtl/xif_copro_result_stage.sv - XIF coprocessor writeback and result stage
// clk_i, rst_ni    : clock, synchronous active-low reset
// bus (slave)      : ex/mem result inputs, crf write port, XIF result handshake
// occupancy_o      : result FIFO fill level
// stat_*_cnt_o     : saturating statistics, present with XIF_COPRO_RESULT_STATS_EN, else 0

module xif_copro_result_stage
    import xif_copro_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    xif_copro_result_stage_if.slave  bus,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [31:0]              stat_ex_cnt_o,
    output logic [31:0]              stat_mem_cnt_o,
    output logic [31:0]              stat_stall_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e rr_q, rr_d;

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    x_result_t     fifo_q [DEPTH];

    logic full, empty;
    logic grant_ex, grant_mem;
    logic push_ex, push_mem, push, pop;

    x_result_t              push_res;
    logic                   crf_qual;
    logic [4:0]             crf_addr_nxt;
    logic [X_RFW_WIDTH-1:0] crf_data_nxt;

    logic                   crf_we_q;
    logic [4:0]             crf_waddr_q;
    logic [X_RFW_WIDTH-1:0] crf_wdata_q;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Arbitration ignores x_result_ready_i so upstream readiness never
    // combinationally depends on the core side.
    assign grant_ex  = bus.ex_valid_i && (!bus.mem_valid_i || rr_q == SRC_EX);
    assign grant_mem = bus.mem_valid_i && !grant_ex;

    assign bus.ex_ready_o  = !full && grant_ex;
    assign bus.mem_ready_o = !full && grant_mem;

    assign push_ex  = bus.ex_ready_o;
    assign push_mem = bus.mem_ready_o;
    assign push     = push_ex || push_mem;
    assign pop      = !empty && bus.x_result_ready_i;

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = push_ex ? SRC_MEM : SRC_EX;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= SRC_EX;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Result formation for whichever source holds the grant this cycle.
    always_comb begin
        push_res     = '0;
        crf_qual     = 1'b0;
        crf_addr_nxt = bus.ex_rd_i;
        crf_data_nxt = bus.ex_data_i;
        if (grant_ex) begin
            push_res.id   = bus.ex_id_i;
            push_res.rd   = bus.ex_rd_i;
            push_res.data = bus.ex_data_i;
            push_res.we   = !bus.ex_rd_is_copro_i;
            crf_qual      = bus.ex_rd_is_copro_i;
        end else begin
            push_res.id      = bus.mem_meta_i.id;
            push_res.rd      = bus.mem_meta_i.rd;
            push_res.exc     = bus.mem_meta_i.exc;
            push_res.exccode = bus.mem_meta_i.exccode;
            push_res.dbg     = bus.mem_meta_i.dbg;
            push_res.we      = bus.mem_meta_i.we && !bus.mem_rd_is_copro_i && !bus.mem_meta_i.exc;
            // A faulting load must not leak bus data to the core.
            push_res.data    = bus.mem_meta_i.exc ? '0 : bus.mem_data_i;
            crf_qual         = bus.mem_rd_is_copro_i && !bus.mem_meta_i.exc;
            crf_addr_nxt     = bus.mem_meta_i.rd;
            crf_data_nxt     = bus.mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= push_res;
        end
    end

    assign bus.x_result_valid_o = !empty;
    assign bus.x_result_o       = empty ? '0 : fifo_q[rptr_q];
    assign occupancy_o          = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crf_we_q    <= 1'b0;
            crf_waddr_q <= '0;
            crf_wdata_q <= '0;
        end else begin
            crf_we_q <= push && crf_qual;
            if (push && crf_qual) begin
                crf_waddr_q <= crf_addr_nxt;
                crf_wdata_q <= crf_data_nxt;
            end
        end
    end

    assign bus.crf_we_o    = crf_we_q;
    assign bus.crf_waddr_o = crf_waddr_q;
    assign bus.crf_wdata_o = crf_wdata_q;

`ifdef XIF_COPRO_RESULT_STATS_EN
    logic [31:0] stat_ex_q, stat_mem_q, stat_stall_q;
    logic        stall;

    assign stall = bus.x_result_valid_o && !bus.x_result_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_ex_q    <= '0;
            stat_mem_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (push_ex && stat_ex_q != '1) begin
                stat_ex_q <= stat_ex_q + 32'd1;
            end
            if (push_mem && stat_mem_q != '1) begin
                stat_mem_q <= stat_mem_q + 32'd1;
            end
            if (stall && stat_stall_q != '1) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_ex_cnt_o    = stat_ex_q;
    assign stat_mem_cnt_o   = stat_mem_q;
    assign stat_stall_cnt_o = stat_stall_q;
`else
    assign stat_ex_cnt_o    = '0;
    assign stat_mem_cnt_o   = '0;
    assign stat_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xif_copro_result_stage.sv
// tb/tb_xif_copro_result_stage.sv - self-checking bench for xif_copro_result_stage

module tb_xif_copro_result_stage;

    import xif_copro_pkg::*;

    localparam int DEPTH = 2;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    xif_copro_result_stage_if bus ();

    logic [$clog2(DEPTH):0] occupancy_o;
    logic [31:0]            stat_ex_cnt_o;
    logic [31:0]            stat_mem_cnt_o;
    logic [31:0]            stat_stall_cnt_o;

    xif_copro_result_stage #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .occupancy_o      (occupancy_o),
        .stat_ex_cnt_o    (stat_ex_cnt_o),
        .stat_mem_cnt_o   (stat_mem_cnt_o),
        .stat_stall_cnt_o (stat_stall_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    x_result_t             exp_q [$];
    x_result_t             act_q [$];
    logic [X_ID_WIDTH-1:0] acc_q [$];
    int unsigned           m_ex, m_mem, m_stall;

    // Scoreboard: expected results are built from the stimulus at the
    // moment it is accepted; observed results are captured on each pop.
    always @(negedge clk_i) begin
        x_result_t r;
        if (!rst_ni) begin
            exp_q.delete();
            act_q.delete();
            acc_q.delete();
            m_ex = 0;
            m_mem = 0;
            m_stall = 0;
        end else begin
            if (bus.x_result_valid_o) begin
                if (bus.x_result_ready_i) act_q.push_back(bus.x_result_o);
                else m_stall++;
            end
            if (bus.ex_valid_i && bus.ex_ready_o) begin
                r = '0;
                r.id = bus.ex_id_i;
                r.rd = bus.ex_rd_i;
                r.data = bus.ex_data_i;
                r.we = !bus.ex_rd_is_copro_i;
                exp_q.push_back(r);
                acc_q.push_back(bus.ex_id_i);
                m_ex++;
            end
            if (bus.mem_valid_i && bus.mem_ready_o) begin
                r = '0;
                r.id = bus.mem_meta_i.id;
                r.rd = bus.mem_meta_i.rd;
                r.exc = bus.mem_meta_i.exc;
                r.exccode = bus.mem_meta_i.exccode;
                r.dbg = bus.mem_meta_i.dbg;
                r.we = bus.mem_meta_i.we && !bus.mem_rd_is_copro_i && !bus.mem_meta_i.exc;
                r.data = bus.mem_meta_i.exc ? 32'h0 : bus.mem_data_i;
                exp_q.push_back(r);
                acc_q.push_back(bus.mem_meta_i.id);
                m_mem++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid_i = 1'b0;
        bus.ex_id_i = '0;
        bus.ex_rd_i = '0;
        bus.ex_rd_is_copro_i = 1'b0;
        bus.ex_data_i = '0;
        bus.mem_valid_i = 1'b0;
        bus.mem_meta_i = '0;
        bus.mem_rd_is_copro_i = 1'b0;
        bus.mem_data_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        bus.x_result_ready_i = 1'b0;
        do_reset();
        n_cmp++; if (bus.x_result_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.x_result_valid_o); end
        n_cmp++; if (occupancy_o !== '0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
        n_cmp++; if (bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_crf_we: got %0b want 0", bus.crf_we_o); end
        n_cmp++; if (bus.crf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL reset_crf_waddr: got %0d want 0", bus.crf_waddr_o); end
        n_cmp++; if (bus.crf_wdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_crf_wdata: got %h want 0", bus.crf_wdata_o); end
        n_cmp++; if (bus.x_result_o !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.x_result_o); end
        n_cmp++; if (bus.ex_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ex_ready_idle: got %0b want 0", bus.ex_ready_o); end
        n_cmp++; if ({stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o} !== 96'h0) begin n_bad++; $display("FAIL reset_stats: got %h %h %h want 0", stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o); end
    endtask

    task automatic test_single_ex();
        x_result_t a, e;
        bus.x_result_ready_i = 1'b1;
        bus.ex_valid_i = 1'b1;
        bus.ex_id_i = 4'd3;
        bus.ex_rd_i = 5'd5;
        bus.ex_rd_is_copro_i = 1'b0;
        bus.ex_data_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_ex_ready: got %0b want 1", bus.ex_ready_o); end
        tick();
        idle_inputs();
        n_cmp++; if (bus.x_result_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", bus.x_result_valid_o); end
        n_cmp++; if (bus.x_result_o.id !== 4'd3) begin n_bad++; $display("FAIL single_id: got %0d want 3", bus.x_result_o.id); end
        n_cmp++; if (bus.x_result_o.rd !== 5'd5) begin n_bad++; $display("FAIL single_rd: got %0d want 5", bus.x_result_o.rd); end
        n_cmp++; if (bus.x_result_o.we !== 1'b1) begin n_bad++; $display("FAIL single_we: got %0b want 1", bus.x_result_o.we); end
        n_cmp++; if (bus.x_result_o.data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h want deadbeef", bus.x_result_o.data); end
        n_cmp++; if (bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL single_crf_we: got %0b want 0", bus.crf_we_o); end
        tick();
        n_cmp++; if (act_q.size() != 1 || exp_q.size() != 1) begin n_bad++; $display("FAIL single_sb_count: got %0d results want %0d", act_q.size(), exp_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL single_sb: got %h want %h", a, e); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_copro();
        x_result_t a, e;
        bus.x_result_ready_i = 1'b1;
        bus.ex_valid_i = 1'b1;
        bus.ex_id_i = 4'd1;
        bus.ex_rd_i = 5'd7;
        bus.ex_rd_is_copro_i = 1'b1;
        bus.ex_data_i = 32'h12345678;
        tick();
        idle_inputs();
        n_cmp++; if (bus.crf_we_o !== 1'b1) begin n_bad++; $display("FAIL copro_crf_we: got %0b want 1", bus.crf_we_o); end
        n_cmp++; if (bus.crf_waddr_o !== 5'd7) begin n_bad++; $display("FAIL copro_crf_waddr: got %0d want 7", bus.crf_waddr_o); end
        n_cmp++; if (bus.crf_wdata_o !== 32'h12345678) begin n_bad++; $display("FAIL copro_crf_wdata: got %h want 12345678", bus.crf_wdata_o); end
        n_cmp++; if (bus.x_result_o.id !== 4'd1 || bus.x_result_o.we !== 1'b0) begin n_bad++; $display("FAIL copro_result: got id %0d we %0b want id 1 we 0", bus.x_result_o.id, bus.x_result_o.we); end
        tick();
        n_cmp++; if (bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL copro_crf_pulse: got %0b want 0", bus.crf_we_o); end
        n_cmp++; if (bus.crf_waddr_o !== 5'd7) begin n_bad++; $display("FAIL copro_crf_hold: got %0d want 7", bus.crf_waddr_o); end
        n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL copro_sb_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL copro_sb: got %h want %h", a, e); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_contention();
        logic [X_ID_WIDTH-1:0] ex_ids [2];
        logic [X_ID_WIDTH-1:0] mem_ids [2];
        logic [X_ID_WIDTH-1:0] order [4];
        int ei, mi, cyc;
        logic acc_ex, acc_mem;
        x_result_t a, e;
        ex_ids[0] = 4'd2; ex_ids[1] = 4'd4;
        mem_ids[0] = 4'd9; mem_ids[1] = 4'd10;
        order[0] = 4'd2; order[1] = 4'd9; order[2] = 4'd4; order[3] = 4'd10;
        bus.x_result_ready_i = 1'b1;
        do_reset();
        ei = 0; mi = 0; cyc = 0;
        while ((ei < 2 || mi < 2) && cyc < 20) begin
            bus.ex_valid_i = (ei < 2);
            bus.ex_id_i = ex_ids[ei % 2];
            bus.ex_rd_i = 5'(ei + 1);
            bus.ex_rd_is_copro_i = 1'b0;
            bus.ex_data_i = 32'hE000_0000 | 32'(ei);
            bus.mem_valid_i = (mi < 2);
            bus.mem_meta_i = '0;
            bus.mem_meta_i.id = mem_ids[mi % 2];
            bus.mem_meta_i.rd = 5'(mi + 10);
            bus.mem_meta_i.we = 1'b1;
            bus.mem_rd_is_copro_i = 1'b0;
            bus.mem_data_i = 32'hD000_0000 | 32'(mi);
            #1;
            acc_ex = bus.ex_valid_i && bus.ex_ready_o;
            acc_mem = bus.mem_valid_i && bus.mem_ready_o;
            tick();
            if (acc_ex) ei++;
            if (acc_mem) mi++;
            cyc++;
        end
        idle_inputs();
        n_cmp++; if (ei < 2 || mi < 2) begin n_bad++; $display("FAIL contention_timeout: got ex %0d mem %0d accepted want 2 2", ei, mi); end
        tick();
        tick();
        n_cmp++; if (acc_q.size() != 4) begin n_bad++; $display("FAIL contention_accept_count: got %0d want 4", acc_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < acc_q.size()) begin
                n_cmp++; if (acc_q[i] !== order[i]) begin n_bad++; $display("FAIL contention_accept_order[%0d]: got %0d want %0d", i, acc_q[i], order[i]); end
            end
            if (i < act_q.size()) begin
                n_cmp++; if (act_q[i].id !== order[i]) begin n_bad++; $display("FAIL contention_result_order[%0d]: got %0d want %0d", i, act_q[i].id, order[i]); end
            end
        end
        n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL contention_sb_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL contention_sb: got %h want %h", a, e); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [X_ID_WIDTH-1:0] bp_ids [3];
        x_result_t a, e;
        bp_ids[0] = 4'd1; bp_ids[1] = 4'd2; bp_ids[2] = 4'd3;
        bus.x_result_ready_i = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            bus.ex_valid_i = 1'b1;
            bus.ex_id_i = bp_ids[i];
            bus.ex_rd_i = 5'(i + 1);
            bus.ex_data_i = 32'h11 * 32'(i + 1);
            tick();
        end
        bus.ex_id_i = 4'd3;
        bus.ex_rd_i = 5'd3;
        bus.ex_data_i = 32'h33;
        bus.mem_valid_i = 1'b1;
        bus.mem_meta_i = '0;
        bus.mem_meta_i.id = 4'd12;
        #1;
        n_cmp++; if (occupancy_o !== 2'd2) begin n_bad++; $display("FAIL bp_occ_full: got %0d want 2", occupancy_o); end
        n_cmp++; if (bus.ex_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got ex %0b mem %0b want 0 0", bus.ex_ready_o, bus.mem_ready_o); end
        tick();
        bus.mem_valid_i = 1'b0;
        bus.x_result_ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.ex_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_blocks_with_pop: got %0b want 0", bus.ex_ready_o); end
        tick();
        n_cmp++; if (bus.ex_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_resume: got %0b want 1", bus.ex_ready_o); end
        tick();
        idle_inputs();
        n_cmp++; if (occupancy_o !== 2'd1) begin n_bad++; $display("FAIL bp_push_pop_occ: got %0d want 1", occupancy_o); end
        tick();
        tick();
        n_cmp++; if (occupancy_o !== 2'd0) begin n_bad++; $display("FAIL bp_drained_occ: got %0d want 0", occupancy_o); end
        n_cmp++; if (act_q.size() != 3) begin n_bad++; $display("FAIL bp_result_count: got %0d want 3", act_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < act_q.size()) begin
                n_cmp++; if (act_q[i].id !== bp_ids[i]) begin n_bad++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, act_q[i].id, bp_ids[i]); end
            end
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL bp_sb: got %h want %h", a, e); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_mem_exception();
        x_result_t a, e;
        bus.x_result_ready_i = 1'b1;
        idle_inputs();
        bus.mem_valid_i = 1'b1;
        bus.mem_meta_i.id = 4'd6;
        bus.mem_meta_i.rd = 5'd9;
        bus.mem_meta_i.we = 1'b1;
        bus.mem_meta_i.exc = 1'b1;
        bus.mem_meta_i.exccode = 6'd5;
        bus.mem_rd_is_copro_i = 1'b1;
        bus.mem_data_i = 32'hFF;
        #1;
        n_cmp++; if (bus.mem_ready_o !== 1'b1) begin n_bad++; $display("FAIL memexc_ready: got %0b want 1", bus.mem_ready_o); end
        tick();
        idle_inputs();
        n_cmp++; if (bus.x_result_o.id !== 4'd6 || bus.x_result_o.exc !== 1'b1 || bus.x_result_o.exccode !== 6'd5) begin n_bad++; $display("FAIL memexc_fields: got id %0d exc %0b code %0d want 6 1 5", bus.x_result_o.id, bus.x_result_o.exc, bus.x_result_o.exccode); end
        n_cmp++; if (bus.x_result_o.we !== 1'b0) begin n_bad++; $display("FAIL memexc_we: got %0b want 0", bus.x_result_o.we); end
        n_cmp++; if (bus.x_result_o.data !== 32'h0) begin n_bad++; $display("FAIL memexc_data: got %h want 0", bus.x_result_o.data); end
        n_cmp++; if (bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL memexc_crf_we: got %0b want 0", bus.crf_we_o); end
        tick();
        n_cmp++; if (act_q.size() != exp_q.size()) begin n_bad++; $display("FAIL memexc_sb_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL memexc_sb: got %h want %h", a, e); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_stats();
`ifdef XIF_COPRO_RESULT_STATS_EN
        n_cmp++; if (stat_ex_cnt_o !== 32'(m_ex)) begin n_bad++; $display("FAIL stats_ex: got %0d want %0d", stat_ex_cnt_o, m_ex); end
        n_cmp++; if (stat_mem_cnt_o !== 32'(m_mem)) begin n_bad++; $display("FAIL stats_mem: got %0d want %0d", stat_mem_cnt_o, m_mem); end
        n_cmp++; if (stat_stall_cnt_o !== 32'(m_stall)) begin n_bad++; $display("FAIL stats_stall: got %0d want %0d", stat_stall_cnt_o, m_stall); end
`else
        n_cmp++; if ({stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o} !== 96'h0) begin n_bad++; $display("FAIL stats_disabled: got %h %h %h want 0", stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        bus.x_result_ready_i = 1'b0;
        idle_inputs();
        bus.ex_valid_i = 1'b1;
        bus.ex_id_i = 4'd1;
        bus.ex_rd_i = 5'd2;
        tick();
        bus.ex_id_i = 4'd2;
        bus.ex_rd_i = 5'd4;
        bus.ex_rd_is_copro_i = 1'b1;
        bus.ex_data_i = 32'hCAFEF00D;
        tick();
        idle_inputs();
        n_cmp++; if (occupancy_o !== 2'd2 || bus.crf_we_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup: got occ %0d crf_we %0b want 2 1", occupancy_o, bus.crf_we_o); end
        rst_ni = 1'b0;
        bus.ex_valid_i = 1'b1;
        bus.ex_rd_is_copro_i = 1'b1;
        tick();
        n_cmp++; if (bus.x_result_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b want 0", bus.x_result_valid_o); end
        n_cmp++; if (occupancy_o !== 2'd0) begin n_bad++; $display("FAIL rstmid_occ: got %0d want 0", occupancy_o); end
        n_cmp++; if (bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_crf_we: got %0b want 0", bus.crf_we_o); end
        n_cmp++; if ({stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o} !== 96'h0) begin n_bad++; $display("FAIL rstmid_stats: got %h %h %h want 0", stat_ex_cnt_o, stat_mem_cnt_o, stat_stall_cnt_o); end
        tick();
        n_cmp++; if (bus.crf_we_o !== 1'b0 || bus.x_result_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_hold: got crf_we %0b valid %0b want 0 0", bus.crf_we_o, bus.x_result_valid_o); end
        idle_inputs();
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (bus.x_result_valid_o !== 1'b0 || occupancy_o !== 2'd0 || bus.crf_we_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got valid %0b occ %0d crf_we %0b want 0 0 0", bus.x_result_valid_o, occupancy_o, bus.crf_we_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        bus.x_result_ready_i = 1'b0;
        idle_inputs();
        test_reset();
        test_single_ex();
        test_copro();
        test_contention();
        test_backpressure();
        test_mem_exception();
        test_stats();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
